// File: rtl/md_issue_ctrl_if.sv
// Handshake bundle between the MD issue arbiter, the MUL/DIV datapath,
// writeback and md_issue_ctrl. master = the sequencer, slave = its environment.
interface md_issue_ctrl_if #(
    parameter int TAG_WIDTH  = 6,
    parameter int ADDR_WIDTH = 4
);
    logic                  flush;
    logic                  iss_valid;
    logic [ADDR_WIDTH-1:0] iss_addr;
    logic                  iss_is_div;
    logic [TAG_WIDTH-1:0]  iss_tag;
    logic                  muti_finish;
    logic                  md_start;
    logic                  md_is_div;
    logic                  md_done;
    logic                  md_kill;
    logic                  wb_valid;
    logic [TAG_WIDTH-1:0]  wb_tag;
    logic                  wb_ready;
    logic                  iq_release;
    logic [ADDR_WIDTH-1:0] iq_rel_addr;

    modport master (
        input  flush, iss_valid, iss_addr, iss_is_div, iss_tag, md_done, wb_ready,
        output muti_finish, md_start, md_is_div, md_kill, wb_valid, wb_tag,
               iq_release, iq_rel_addr
    );

    modport slave (
        output flush, iss_valid, iss_addr, iss_is_div, iss_tag, md_done, wb_ready,
        input  muti_finish, md_start, md_is_div, md_kill, wb_valid, wb_tag,
               iq_release, iq_rel_addr
    );
endinterface

// File: rtl/md_issue_ctrl.sv
// md_issue_ctrl: sequencer for the shared multi-cycle MUL/DIV unit.
// Takes one granted MD issue-queue entry at a time, times its latency with a
// down-counter, presents the result to writeback and frees the queue slot.
// Optional build macro MD_BACK2BACK_EN: lets a new op be accepted in the same
// cycle the previous result is taken by writeback (zero-bubble issue).
//
// state  | meaning
// IDLE   | unit free, muti_finish=1, waiting for an arbiter grant
// BUSY   | op running in the datapath, counter decrementing
// WB     | result offered to writeback, held until wb_ready
module md_issue_ctrl #(
    parameter int MUL_LAT    = 3,
    parameter int DIV_LAT    = 34,
    parameter int TAG_WIDTH  = 6,
    parameter int ADDR_WIDTH = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    md_issue_ctrl_if.master bus
);
    localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int CNT_W   = $clog2(MAX_LAT + 1);

    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_LAT - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_LAT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_WB   = 2'd2;

    logic [1:0]            state;
    logic [CNT_W-1:0]      cnt;
    logic                  start_q;
    logic                  is_div_q;
    logic [TAG_WIDTH-1:0]  tag_q;
    logic [ADDR_WIDTH-1:0] addr_q;

    logic                  muti_finish;
    logic                  wb_take;
    logic                  accept;
    logic                  busy_end;
    logic [CNT_W-1:0]      cnt_load;

    // a flush in the same cycle blocks both the writeback handoff and a new grant
    assign wb_take  = (state == S_WB) && bus.wb_ready && !bus.flush;
`ifdef MD_BACK2BACK_EN
    assign muti_finish = (state == S_IDLE) || wb_take;
`else
    assign muti_finish = (state == S_IDLE);
`endif
    assign accept   = bus.iss_valid && muti_finish && !bus.flush;
    assign busy_end = (cnt == '0) || (bus.md_done && is_div_q);
    assign cnt_load = bus.iss_is_div ? DIV_LOAD : MUL_LOAD;

    assign bus.muti_finish = muti_finish;
    assign bus.md_start    = (state == S_BUSY) && start_q;
    assign bus.md_is_div   = (state == S_BUSY) && is_div_q;
    assign bus.md_kill     = (state == S_BUSY) && bus.flush;
    assign bus.wb_valid    = (state == S_WB);
    assign bus.wb_tag      = (state == S_WB) ? tag_q : '0;
    assign bus.iq_release  = wb_take;
    assign bus.iq_rel_addr = wb_take ? addr_q : '0;

    // state and latency counter; flush overrides every state
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            cnt     <= '0;
            start_q <= 1'b0;
        end else begin
            start_q <= accept;
            if (bus.flush) begin
                state <= S_IDLE;
                cnt   <= '0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (accept) begin
                            state <= S_BUSY;
                            cnt   <= cnt_load;
                        end
                    end
                    S_BUSY: begin
                        if (busy_end) begin
                            state <= S_WB;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt - CNT_ONE;
                        end
                    end
                    S_WB: begin
                        if (bus.wb_ready) begin
                            if (accept) begin
                                state <= S_BUSY;
                                cnt   <= cnt_load;
                            end else begin
                                state <= S_IDLE;
                            end
                        end
                    end
                    default: begin
                        state <= S_IDLE;
                        cnt   <= '0;
                    end
                endcase
            end
        end
    end

    // capture the granted op; held until the next accepted grant
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            is_div_q <= 1'b0;
            tag_q    <= '0;
            addr_q   <= '0;
        end else if (accept) begin
            is_div_q <= bus.iss_is_div;
            tag_q    <= bus.iss_tag;
            addr_q   <= bus.iss_addr;
        end
    end

`ifndef SYNTHESIS
    // a grant while the unit cannot accept is dropped; flag it so arbiter bugs are visible
    always_ff @(posedge clk) begin
        if (rst_n) begin
            assert (!(bus.iss_valid && !muti_finish))
                else $warning("md_issue_ctrl: iss_valid while unit busy, grant ignored");
        end
    end
`endif
endmodule

// File: tb/tb_md_issue_ctrl.sv
// Scoreboard bench for md_issue_ctrl (MUL_LAT=3, DIV_LAT=34).
// Stimulus pushes the expected writeback (tag, addr, cycle) into a queue; the
// monitor compares whenever wb_valid is shown and pops on the accept cycle.
module tb_md_issue_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    md_issue_ctrl_if #(.TAG_WIDTH(6), .ADDR_WIDTH(4)) bus ();

    md_issue_ctrl #(
        .MUL_LAT(3), .DIV_LAT(34), .TAG_WIDTH(6), .ADDR_WIDTH(4)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    typedef struct {
        logic [5:0] tag;
        logic [3:0] addr;
        int         cyc;
    } exp_t;

    exp_t sb[$];
    int cyc = 0;
    int errors = 0;
    int checks = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @cyc %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic at(input int c);
        while (cyc < c) tick();
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic push(input logic [5:0] tag, input logic [3:0] addr, input int c);
        exp_t e;
        e.tag = tag;
        e.addr = addr;
        e.cyc = c;
        sb.push_back(e);
    endtask

    task automatic grant(input logic [5:0] tag, input logic [3:0] addr, input logic div);
        bus.iss_valid  = 1'b1;
        bus.iss_tag    = tag;
        bus.iss_addr   = addr;
        bus.iss_is_div = div;
    endtask

    // writeback monitor: tag while valid, slot/cycle on the accept cycle
    always @(negedge clk) begin
        if (rst_n && bus.wb_valid) begin
            if (sb.size() == 0) begin
                chk("wb_unexpected", 32'(bus.wb_valid), 32'd0);
            end else begin
                chk("wb_tag", 32'(bus.wb_tag), 32'(sb[0].tag));
                if (bus.wb_ready && !bus.flush) begin
                    chk("wb_cycle", 32'(cyc), 32'(sb[0].cyc));
                    chk("iq_release", 32'(bus.iq_release), 32'd1);
                    chk("iq_rel_addr", 32'(bus.iq_rel_addr), 32'(sb[0].addr));
                    void'(sb.pop_front());
                end
            end
        end
    end

    initial begin
        #20000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        int c1;
        int acc;
        int exp_acc;

        bus.flush = 0; bus.iss_valid = 0; bus.iss_addr = 0; bus.iss_is_div = 0;
        bus.iss_tag = 0; bus.md_done = 0; bus.wb_ready = 1;

        // reset state
        repeat (2) tick();
        smp();
        chk("rst_muti_finish", 32'(bus.muti_finish), 1);
        chk("rst_md_start", 32'(bus.md_start), 0);
        chk("rst_wb_valid", 32'(bus.wb_valid), 0);
        chk("rst_iq_release", 32'(bus.iq_release), 0);
        chk("rst_md_kill", 32'(bus.md_kill), 0);
        chk("rst_wb_tag", 32'(bus.wb_tag), 0);
        tick(); rst_n = 1;
        repeat (2) tick();

        // 1: MUL, addr 3 tag 5
        tick(); c0 = cyc; grant(6'd5, 4'd3, 1'b0); push(6'd5, 4'd3, c0 + 4);
        smp(); chk("t1_mf_idle", 32'(bus.muti_finish), 1);
        at(c0 + 1); bus.iss_valid = 0;
        smp(); chk("t1_md_start", 32'(bus.md_start), 1);
        chk("t1_mf_busy", 32'(bus.muti_finish), 0);
        chk("t1_md_is_div", 32'(bus.md_is_div), 0);
        at(c0 + 2); smp(); chk("t1_start_once", 32'(bus.md_start), 0);
        at(c0 + 4); smp(); chk("t1_iq_release", 32'(bus.iq_release), 1);
        at(c0 + 5); smp(); chk("t1_mf_after", 32'(bus.muti_finish), 1);

        // 2a: DIV with early md_done at c0+10
        tick(); c0 = cyc; grant(6'd9, 4'd7, 1'b1); push(6'd9, 4'd7, c0 + 11);
        at(c0 + 1); bus.iss_valid = 0;
        at(c0 + 5); smp(); chk("t2a_md_is_div", 32'(bus.md_is_div), 1);
        at(c0 + 10); bus.md_done = 1;
        smp(); chk("t2a_no_wb_yet", 32'(bus.wb_valid), 0);
        at(c0 + 11); bus.md_done = 0;
        smp(); chk("t2a_wb_valid", 32'(bus.wb_valid), 1);
        at(c0 + 12);

        // 2b: DIV full latency
        tick(); c0 = cyc; grant(6'd10, 4'd8, 1'b1); push(6'd10, 4'd8, c0 + 35);
        at(c0 + 1); bus.iss_valid = 0;
        at(c0 + 34); smp(); chk("t2b_no_wb_yet", 32'(bus.wb_valid), 0);
        at(c0 + 35); smp(); chk("t2b_wb_valid", 32'(bus.wb_valid), 1);
        at(c0 + 36);

        // 2c: md_done during MUL is ignored
        tick(); c0 = cyc; grant(6'd13, 4'd1, 1'b0); push(6'd13, 4'd1, c0 + 4);
        at(c0 + 1); bus.iss_valid = 0; bus.md_done = 1;
        at(c0 + 2); bus.md_done = 0;
        at(c0 + 3); smp(); chk("t2c_no_early_wb", 32'(bus.wb_valid), 0);
        at(c0 + 4); smp(); chk("t2c_wb_valid", 32'(bus.wb_valid), 1);
        at(c0 + 5);

        // 3: backpressure for 5 WB cycles
        bus.wb_ready = 0;
        tick(); c0 = cyc; grant(6'd21, 4'd6, 1'b0); push(6'd21, 4'd6, c0 + 9);
        at(c0 + 1); bus.iss_valid = 0;
        for (int k = 4; k <= 8; k++) begin
            at(c0 + k); smp();
            chk("t3_wb_hold", 32'(bus.wb_valid), 1);
            chk("t3_mf_low", 32'(bus.muti_finish), 0);
            chk("t3_no_release", 32'(bus.iq_release), 0);
        end
        at(c0 + 9); bus.wb_ready = 1;
        smp(); chk("t3_release", 32'(bus.iq_release), 1);
        at(c0 + 10);

        // 4: flush in the second BUSY cycle
        tick(); c0 = cyc; grant(6'd30, 4'd9, 1'b0);
        at(c0 + 1); bus.iss_valid = 0;
        smp(); chk("t4_no_kill_early", 32'(bus.md_kill), 0);
        at(c0 + 2); bus.flush = 1;
        smp(); chk("t4_md_kill", 32'(bus.md_kill), 1);
        at(c0 + 3); bus.flush = 0;
        smp(); chk("t4_mf_after", 32'(bus.muti_finish), 1);
        chk("t4_kill_once", 32'(bus.md_kill), 0);
        chk("t4_no_release", 32'(bus.iq_release), 0);
        at(c0 + 8);

        // 4b: flush with grant in IDLE
        tick(); c0 = cyc; grant(6'd31, 4'd5, 1'b0); bus.flush = 1;
        at(c0 + 1); bus.flush = 0; bus.iss_valid = 0;
        smp(); chk("t4b_no_start", 32'(bus.md_start), 0);
        chk("t4b_mf", 32'(bus.muti_finish), 1);
        at(c0 + 6);

        // 5: reset during BUSY, then a normal op
        tick(); c0 = cyc; grant(6'd40, 4'd10, 1'b1);
        at(c0 + 1); bus.iss_valid = 0;
        at(c0 + 2); rst_n = 0;
        smp(); chk("t5_no_kill", 32'(bus.md_kill), 0);
        at(c0 + 3); rst_n = 1;
        smp();
        chk("t5_mf", 32'(bus.muti_finish), 1);
        chk("t5_md_start", 32'(bus.md_start), 0);
        chk("t5_md_is_div", 32'(bus.md_is_div), 0);
        chk("t5_wb_valid", 32'(bus.wb_valid), 0);
        chk("t5_iq_release", 32'(bus.iq_release), 0);
        chk("t5_md_kill", 32'(bus.md_kill), 0);
        tick(); c1 = cyc; grant(6'd41, 4'd11, 1'b0); push(6'd41, 4'd11, c1 + 4);
        at(c1 + 1); bus.iss_valid = 0;
        smp(); chk("t5_new_start", 32'(bus.md_start), 1);
        at(c1 + 5);

        // 6: grant raised in the WB accept cycle and held until taken
        tick(); c0 = cyc; grant(6'd50, 4'd2, 1'b0); push(6'd50, 4'd2, c0 + 4);
        at(c0 + 1); bus.iss_valid = 0;
        at(c0 + 4); grant(6'd51, 4'd4, 1'b0);
`ifdef MD_BACK2BACK_EN
        exp_acc = c0 + 4;
`else
        exp_acc = c0 + 5;
`endif
        acc = -1;
        for (int k = 0; k < 4 && acc < 0; k++) begin
            if (k > 0) tick();
            smp();
            if (bus.muti_finish) acc = cyc;
        end
        chk("t6_accept_cycle", 32'(acc), 32'(exp_acc));
        push(6'd51, 4'd4, exp_acc + 4);
        tick(); bus.iss_valid = 0;
        smp(); chk("t6_md_start", 32'(bus.md_start), 1);
        at(exp_acc + 6);

        smp(); chk("sb_drained", 32'(sb.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
